// File: rtl/serial_instr_rx_pkg.sv
// Shared types and constants for the MBED serial instruction receiver.
// Imported by the interface, the synchroniser and the receiver top.
package serial_instr_pkg;

    localparam int INSTR_WIDTH_DEFAULT = 11;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Width needed to count 0..w received bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_instr_rx_if.sv
// Valid/ready instruction channel between the receiver and the
// servo command decoder.
interface serial_instr_rx_if
    import serial_instr_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] instruction;
    logic             instr_valid;
    logic             instr_ready;

    modport master (
        output instruction,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/serial_instr_rx_bit_sync_edge.sv
// Multi-flop synchroniser with a registered level and optional rising edge.
// Level and edge outputs describe the same synchronised sample.
module bit_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync;

    // Synchroniser chain, one extra register for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            q    <= sync[STAGES-1];
            rise <= EDGE_EN & sync[STAGES-1] & ~q;
        end
    end

endmodule

// File: rtl/serial_instr_rx.sv
// Bit-serial instruction receiver: assembles WIDTH-bit frames from the
// MBED set/confirm lines and offers them over a valid/ready channel.
module serial_instr_rx
    import serial_instr_pkg::*;
#(
    parameter int WIDTH          = INSTR_WIDTH_DEFAULT,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        set_bit,
    input  logic                        confirm_bit,
    input  logic                        clear,
    serial_instr_rx_if.master           io,
    output logic                        busy,
    output logic [cnt_width(WIDTH)-1:0] bit_count,
    output logic                        timeout_err,
    output logic                        overrun_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    logic             data_bit;
    logic             cedge;
    logic             sdata_rise_unused;

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             tout_q, tout_d;

    logic             accept;
    logic             last;
    logic             xfer;
    logic [WIDTH-1:0] shifted;

    bit_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_sync_confirm (
        .clk   (clk),
        .reset (reset),
        .d     (confirm_bit),
        .q     (),
        .rise  (cedge)
    );

    bit_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .d     (set_bit),
        .q     (data_bit),
        .rise  (sdata_rise_unused)
    );

    assign accept  = cedge & enable & ~clear;
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign xfer    = valid_q & io.instr_ready;
    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], data_bit}
                               : {data_bit, shreg_q[WIDTH-1:1]};

    // Next-state: clear, then accepted bit, then timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tcnt_d  = tcnt_q;
        instr_d = instr_q;
        valid_d = valid_q & ~xfer;
        ovr_d   = ovr_q;
        tout_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            tcnt_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (accept) begin
            shreg_d = shifted;
            tcnt_d  = '0;
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!valid_q || xfer) begin
                    instr_d = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (state_q == SHIFT && TIMEOUT_CYCLES != 0) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
                state_d = IDLE;
                cnt_d   = '0;
                tcnt_d  = '0;
                tout_d  = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            tcnt_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            tcnt_q  <= tcnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            tout_q  <= tout_d;
        end
    end

    assign io.instruction = instr_q;
    assign io.instr_valid = valid_q;
    assign busy           = (cnt_q != '0);
    assign bit_count      = cnt_q;
    assign timeout_err    = tout_q;
    assign overrun_err    = ovr_q;

endmodule
